lock_controller: RTL and testbench
==================================

// Module: lock_controller
// PURPOSE
//  Top-level sequencer for the digital lock. Drives the code-entry register's shift/clear
//  (clear wired to that register's rst), reads back its 24b code and 3b length, and holds
//  the stored password. Compares attempts against it, counts failures, enforces lockout,
//  and runs the reprogramming sequence. Sits between the debounced keypad and the lock actuator.
// PARAMETERS
//  RESET_CODE     24'h001234  password loaded on rst, right-aligned nibbles
//  RESET_LEN      3'd4        length of RESET_CODE in digits
//  MIN_LEN        3'd4        shortest password accepted when reprogramming
//  MAX_FAILS      3           consecutive failed attempts that trigger lockout
//  LOCKOUT_CYCLES 1000        cycles spent in LOCKOUT
//  UNLOCK_CYCLES  500         auto-relock timeout (only with AUTO_RELOCK_EN)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous, active-high reset
//  key_valid  in   1   1-cycle pulse: key holds a digit
//  key        in   4   digit value
//  enter      in   1   1-cycle pulse: submit entry
//  program    in   1   1-cycle pulse: start reprogramming (honoured only in UNLOCKED)
//  lock_req   in   1   1-cycle pulse: relock from UNLOCKED
//  newcode    in   24  code-entry register contents
//  length     in   3   code-entry register digit count
//  shift      out  1   shift key into code-entry register this cycle
//  clear      out  1   clear code-entry register this cycle
//  unlocked   out  1   actuator drive, high only in UNLOCKED
//  alarm      out  1   high in LOCKOUT
//  prog_err   out  1   1-cycle pulse: rejected reprogram (too short)
//  state      out  3   encoded FSM state, for display/debug
// BEHAVIOUR
//  - Reset: FSM=LOCKED; fails=0; stored=RESET_CODE/RESET_LEN; shift, clear, unlocked, alarm, prog_err=0.
//  - States: LOCKED(0) ENTRY(1) SETTLE(2) CHECK(3) UNLOCKED(4) PROG(5) PSETTLE(6) LOCKOUT(7).
//  - LOCKED: first key_valid -> clear=1 this cycle, go to ENTRY; that key is dropped. Re-press it.
//  - ENTRY/PROG: key_valid && length<6 -> shift=1. At length>=6, further keys are ignored.
//  - ENTRY/PROG: enter -> SETTLE/PSETTLE. Same-cycle key_valid+enter: key is shifted first,
//    then the state advances. SETTLE is one cycle, so the register has updated before compare.
//  - CHECK: match = (length==stored_len) && (newcode==stored_code), compared across all 24 bits.
//    Match -> UNLOCKED, fails=0, clear=1.
//    Miss -> fails+1, clear=1, then LOCKED. If fails reaches MAX_FAILS -> LOCKOUT instead.
//  - Latency: enter at cycle t -> unlocked high at t+2 (SETTLE t+1, CHECK t+2 registers it).
//  - LOCKOUT: alarm=1. All inputs are ignored for LOCKOUT_CYCLES. Then fails=0 and go to LOCKED.
//  - UNLOCKED: lock_req -> LOCKED. program -> clear=1 and go to PROG.
//    lock_req has priority over a simultaneous program.
//  - PSETTLE: length>=MIN_LEN -> store newcode/length, clear=1, go to LOCKED.
//    Otherwise prog_err=1, clear=1, return to UNLOCKED. The old password is kept.
//  - shift and clear are never high in the same cycle.
//  - fails saturates at MAX_FAILS. The lockout counter is sized $clog2(LOCKOUT_CYCLES+1).
//  - rst in any state, mid-entry included, restores the reset values. stored reverts to RESET_CODE.
// CONFIGURATION
//  AUTO_RELOCK_EN defined: UNLOCKED counts cycles and returns to LOCKED after UNLOCK_CYCLES.
//    The counter restarts on every entry to UNLOCKED. lock_req still relocks early.
//    Time spent in PROG/PSETTLE pauses relock; return from PSETTLE restarts the count.
//  Undefined: no timer. UNLOCKED persists until lock_req or rst.
// TESTING
//  rst; keys 1,2,3,4 (after a wake key); enter -> shift x4, unlocked=1 exactly 2 cycles after enter.
//  Keys 1,2,3 + enter -> unlocked stays 0, back to LOCKED. Repeated 3x -> alarm=1 for 1000 cycles, then LOCKED.
//  Key 4 with enter in the same cycle after 1,2,3 -> unlocks (key shifted before compare).
//  Unlocked, program, keys 9,8 + enter -> prog_err pulse, old code 1234 still unlocks.
//    Program 9,8,7,6,5 + enter -> new code 98765 unlocks, 1234 fails.
//  7 keys in ENTRY -> shift exactly 6 times. AUTO_RELOCK_EN: unlocked drops after 500 idle cycles.
//  rst asserted mid-entry and mid-LOCKOUT -> all outputs 0, state=0, RESET_CODE accepted.

Source files
------------

// File: rtl/lock_controller.sv
// Digital lock sequencer: code entry, compare, fail counting, lockout and reprogramming.
// Optional AUTO_RELOCK_EN adds an idle relock timer in UNLOCKED; prog is the program pulse (program is reserved).
module lock_controller #(
  parameter logic [23:0] RESET_CODE     = 24'h001234,
  parameter logic [2:0]  RESET_LEN      = 3'd4,
  parameter logic [2:0]  MIN_LEN        = 3'd4,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned UNLOCK_CYCLES  = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key,
  input  logic        enter,
  input  logic        prog,
  input  logic        lock_req,
  input  logic [23:0] newcode,
  input  logic [2:0]  length,
  output logic        shift,
  output logic        clear,
  output logic        unlocked,
  output logic        alarm,
  output logic        prog_err,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_LOCKED   = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_CHECK    = 3'd3,
    ST_UNLOCKED = 3'd4,
    ST_PROG     = 3'd5,
    ST_PSETTLE  = 3'd6,
    ST_LOCKOUT  = 3'd7
  } state_t;

  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int unsigned LCK_W  = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [FAIL_W-1:0] FAILS_MAX = FAIL_W'(MAX_FAILS);
  localparam logic [LCK_W-1:0]  LCK_LAST  = LCK_W'(LOCKOUT_CYCLES - 1);

  function automatic logic code_match(input logic [23:0] a_code, input logic [2:0] a_len,
                                      input logic [23:0] b_code, input logic [2:0] b_len);
    return (a_len == b_len) && (a_code == b_code);
  endfunction

  state_t              state_r, state_s;
  logic [FAIL_W-1:0]   fails_r, fails_s, fails_inc_s;
  logic [LCK_W-1:0]    lock_cnt_r, lock_cnt_s;
  logic [23:0]         stored_code_r;
  logic [2:0]          stored_len_r;
  logic                store_s, shift_s, clear_s, prog_err_s, relock_s;
  logic                unlocked_r, alarm_r, prog_err_r;

`ifdef AUTO_RELOCK_EN
  localparam int unsigned REL_W = $clog2(UNLOCK_CYCLES + 1);
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(UNLOCK_CYCLES - 1);
  logic [REL_W-1:0] relock_cnt_r, relock_cnt_s;

  // Idle timer: runs only while UNLOCKED, so every entry restarts it from zero.
  always_comb begin
    relock_cnt_s = '0;
    relock_s     = 1'b0;
    if (state_r == ST_UNLOCKED) begin
      if (relock_cnt_r == REL_LAST) begin
        relock_s = 1'b1;
      end else begin
        relock_cnt_s = relock_cnt_r + REL_W'(1);
      end
    end else begin
      relock_cnt_s = '0;
    end
  end

  // Relock timer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      relock_cnt_r <= '0;
    end else begin
      relock_cnt_r <= relock_cnt_s;
    end
  end
`else
  logic relock_unused_s;
  assign relock_unused_s = (UNLOCK_CYCLES == 0);
  assign relock_s        = 1'b0;
`endif

  // Next-state, fail/lockout counters and the code-register strobes.
  always_comb begin
    state_s     = state_r;
    fails_s     = fails_r;
    lock_cnt_s  = '0;
    store_s     = 1'b0;
    shift_s     = 1'b0;
    clear_s     = 1'b0;
    prog_err_s  = 1'b0;
    if (fails_r < FAILS_MAX) begin
      fails_inc_s = fails_r + FAIL_W'(1);
    end else begin
      fails_inc_s = fails_r;
    end
    case (state_r)
      ST_LOCKED: begin
        if (key_valid) begin
          clear_s = 1'b1;
          state_s = ST_ENTRY;
        end else begin
          state_s = ST_LOCKED;
        end
      end
      ST_ENTRY, ST_PROG: begin
        if (key_valid && (length < 3'd6)) begin
          shift_s = 1'b1;
        end else begin
          shift_s = 1'b0;
        end
        if (enter) begin
          state_s = (state_r == ST_ENTRY) ? ST_SETTLE : ST_PSETTLE;
        end else begin
          state_s = state_r;
        end
      end
      ST_SETTLE: state_s = ST_CHECK;
      ST_CHECK: begin
        clear_s = 1'b1;
        if (code_match(newcode, length, stored_code_r, stored_len_r)) begin
          fails_s = '0;
          state_s = ST_UNLOCKED;
        end else if (fails_inc_s == FAILS_MAX) begin
          fails_s = fails_inc_s;
          state_s = ST_LOCKOUT;
        end else begin
          fails_s = fails_inc_s;
          state_s = ST_LOCKED;
        end
      end
      ST_UNLOCKED: begin
        if (lock_req) begin
          state_s = ST_LOCKED;
        end else if (prog) begin
          clear_s = 1'b1;
          state_s = ST_PROG;
        end else if (relock_s) begin
          state_s = ST_LOCKED;
        end else begin
          state_s = ST_UNLOCKED;
        end
      end
      ST_PSETTLE: begin
        clear_s = 1'b1;
        if (length >= MIN_LEN) begin
          store_s = 1'b1;
          state_s = ST_LOCKED;
        end else begin
          prog_err_s = 1'b1;
          state_s    = ST_UNLOCKED;
        end
      end
      ST_LOCKOUT: begin
        if (lock_cnt_r == LCK_LAST) begin
          fails_s = '0;
          state_s = ST_LOCKED;
        end else begin
          lock_cnt_s = lock_cnt_r + LCK_W'(1);
        end
      end
      default: state_s = ST_LOCKED;
    endcase
  end

  // State, counters, stored password and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_LOCKED;
      fails_r       <= '0;
      lock_cnt_r    <= '0;
      stored_code_r <= RESET_CODE;
      stored_len_r  <= RESET_LEN;
      unlocked_r    <= 1'b0;
      alarm_r       <= 1'b0;
      prog_err_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      fails_r    <= fails_s;
      lock_cnt_r <= lock_cnt_s;
      if (store_s) begin
        stored_code_r <= newcode;
        stored_len_r  <= length;
      end else begin
        stored_code_r <= stored_code_r;
        stored_len_r  <= stored_len_r;
      end
      unlocked_r <= (state_s == ST_UNLOCKED);
      alarm_r    <= (state_s == ST_LOCKOUT);
      prog_err_r <= prog_err_s;
    end
  end

  // shift/clear must act on the key in the same cycle, so they stay combinational.
  assign shift    = shift_s & ~rst;
  assign clear    = clear_s & ~rst;
  assign unlocked = unlocked_r;
  assign alarm    = alarm_r;
  assign prog_err = prog_err_r;
  assign state    = state_r;

endmodule

// File: tb/tb_lock_controller.sv
// Directed bench for lock_controller with a behavioural code-entry register model.
module tb_lock_controller;
  logic        clk = 1'b0;
  logic        rst, key_valid, enter, prog, lock_req;
  logic [3:0]  key;
  logic [23:0] cr_code;
  logic [2:0]  cr_len;
  logic        shift, clear, unlocked, alarm, prog_err;
  logic [2:0]  state;
  int          checks = 0;
  int          errors = 0;
  int          shift_cnt = 0;

  always #5 clk = ~clk;

  lock_controller dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key(key), .enter(enter),
    .prog(prog), .lock_req(lock_req), .newcode(cr_code), .length(cr_len),
    .shift(shift), .clear(clear), .unlocked(unlocked), .alarm(alarm),
    .prog_err(prog_err), .state(state)
  );

  // Code-entry register: clear is its reset, shift appends a nibble on the right.
  always @(posedge clk) begin
    if (rst || clear) begin
      cr_code <= 24'h000000;
      cr_len  <= 3'd0;
    end else if (shift) begin
      cr_code <= {cr_code[19:0], key};
      cr_len  <= cr_len + 3'd1;
    end
  end

  always @(posedge clk) if (shift === 1'b1) shift_cnt <= shift_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key       = d;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic attempt(input logic [23:0] code, input int n);
    press(4'hF);
    for (int i = n - 1; i >= 0; i--) press(code[4*i +: 4]);
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int base;
    int n;
    rst = 1'b1; key_valid = 1'b0; key = 4'h0; enter = 1'b0; prog = 1'b0; lock_req = 1'b0;
    repeat (3) tick();
    chk("rst_state", state, 3'd0);
    chk("rst_unlocked", unlocked, 1'b0);
    chk("rst_alarm", alarm, 1'b0);
    chk("rst_prog_err", prog_err, 1'b0);
    chk("rst_shift", shift, 1'b0);
    chk("rst_clear", clear, 1'b0);
    rst = 1'b0;
    tick();

    // Wake key: cleared, not shifted.
    key_valid = 1'b1; key = 4'h1; #1;
    chk("wake_clear", clear, 1'b1);
    chk("wake_shift", shift, 1'b0);
    tick();
    key_valid = 1'b0;
    chk("wake_state", state, 3'd1);
    base = shift_cnt;
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    chk("shift_x4", shift_cnt - base, 4);
    chk("len_4", cr_len, 3'd4);
    enter = 1'b1;
    tick();
    enter = 1'b0;
    chk("settle_state", state, 3'd2);
    tick();
    chk("check_state", state, 3'd3);
    chk("t1_unlocked", unlocked, 1'b0);
    tick();
    chk("t2_unlocked", unlocked, 1'b1);
    chk("unlocked_state", state, 3'd4);
    lock_req = 1'b1; tick(); lock_req = 1'b0;
    chk("relock_state", state, 3'd0);
    chk("relock_unlocked", unlocked, 1'b0);

    // Three short attempts lead to lockout.
    for (int a = 0; a < 3; a++) begin
      press(4'hF); press(4'h1); press(4'h2); press(4'h3);
      enter = 1'b1; tick(); enter = 1'b0; tick();
      chk("miss_clear", clear, 1'b1);
      tick();
      chk("miss_unlocked", unlocked, 1'b0);
      chk("miss_state", state, (a < 2) ? 3'd0 : 3'd7);
    end
    chk("lockout_alarm", alarm, 1'b1);
    n = 0;
    while (alarm === 1'b1 && n < 2000) begin
      n++;
      key_valid = (n % 7 == 0);
      key       = 4'h1;
      enter     = (n % 11 == 0);
      tick();
    end
    key_valid = 1'b0; enter = 1'b0;
    chk("lockout_cycles", n, 1000);
    chk("after_lockout_state", state, 3'd0);
    attempt(24'h000123, 3);
    chk("fails_cleared", state, 3'd0);

    // Last key and enter in the same cycle.
    press(4'hF); press(4'h1); press(4'h2); press(4'h3);
    key_valid = 1'b1; key = 4'h4; enter = 1'b1;
    tick();
    key_valid = 1'b0; enter = 1'b0;
    tick(); tick();
    chk("same_cycle_unlock", unlocked, 1'b1);

    // Too-short reprogram is rejected.
    prog = 1'b1; #1;
    chk("prog_clear", clear, 1'b1);
    tick(); prog = 1'b0;
    chk("prog_state", state, 3'd5);
    press(4'h9); press(4'h8);
    enter = 1'b1; tick(); enter = 1'b0;
    chk("psettle_state", state, 3'd6);
    tick();
    chk("prog_err_pulse", prog_err, 1'b1);
    chk("prog_err_state", state, 3'd4);
    tick();
    chk("prog_err_drop", prog_err, 1'b0);
    lock_req = 1'b1; prog = 1'b1; tick(); lock_req = 1'b0; prog = 1'b0;
    chk("lock_over_prog", state, 3'd0);
    attempt(24'h001234, 4);
    chk("old_code_kept", unlocked, 1'b1);

    // Valid reprogram to 98765.
    prog = 1'b1; tick(); prog = 1'b0;
    press(4'h9); press(4'h8); press(4'h7); press(4'h6); press(4'h5);
    enter = 1'b1; tick(); enter = 1'b0; tick();
    chk("prog_ok_state", state, 3'd0);
    chk("prog_ok_err", prog_err, 1'b0);
    attempt(24'h098765, 5);
    chk("new_code_unlock", unlocked, 1'b1);
    lock_req = 1'b1; tick(); lock_req = 1'b0;
    attempt(24'h001234, 4);
    chk("old_code_rejected", unlocked, 1'b0);

    // Seven keys shift only six; then reset mid-entry.
    press(4'hF);
    base = shift_cnt;
    for (int d = 1; d <= 7; d++) press(4'(d));
    chk("shift_sat_6", shift_cnt - base, 6);
    chk("len_sat_6", cr_len, 3'd6);
    rst = 1'b1; key_valid = 1'b1; key = 4'h2; tick();
    chk("rst_entry_state", state, 3'd0);
    chk("rst_entry_shift", shift, 1'b0);
    chk("rst_entry_clear", clear, 1'b0);
    chk("rst_entry_unlocked", unlocked, 1'b0);
    rst = 1'b0; key_valid = 1'b0; tick();
    attempt(24'h001234, 4);
    chk("reset_code_restored", unlocked, 1'b1);
`ifdef AUTO_RELOCK_EN
    n = 0;
    while (unlocked === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
    chk("auto_relock_cycles", n, 500);
`else
    repeat (600) tick();
    chk("no_auto_relock", unlocked, 1'b1);
    lock_req = 1'b1; tick(); lock_req = 1'b0;
`endif

    // Reset during lockout.
    for (int a = 0; a < 3; a++) attempt(24'h000123, 3);
    chk("lockout_again", state, 3'd7);
    repeat (5) tick();
    rst = 1'b1; tick();
    chk("rst_lockout_alarm", alarm, 1'b0);
    chk("rst_lockout_state", state, 3'd0);
    chk("rst_lockout_unlocked", unlocked, 1'b0);
    rst = 1'b0; tick();
    attempt(24'h001234, 4);
    chk("post_rst_unlock", unlocked, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
